// File: rtl/adc_sched_pkg.sv
// rtl/adc_sched_pkg.sv - shared types and defaults for the ADC sample scheduler
//
// Purpose: state encoding, default widths/limits and requester IDs used by
//          adc_sample_scheduler and rr_arb2.
// Ports:   none (package).

package adc_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  localparam int SAMPLE_W_DEF = 8;
  localparam int TIMEOUT_DEF  = 32;
  localparam int TMR_W_DEF    = 6;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  // One-hot grant vector for a requester index.
  function automatic logic [1:0] id_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/adc_sample_scheduler_rr_arb2.sv
// rtl/adc_sample_scheduler_rr_arb2.sv - two-way round-robin picker
//
// Purpose: picks which requester is served next. Purely combinational; the
//          last-served pointer is held by the parent.
// Ports:
//   req  in  2  request levels
//   last in  1  index of the requester served most recently
//   sel  out 1  chosen requester index (meaningful only when any=1)
//   any  out 1  at least one request is pending

module rr_arb2
  import adc_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel,
  output logic       any
);

  always_comb begin
    any = |req;
    // A lone request wins outright; on contention the one not served last wins.
    if (req[0]) begin
      sel = req[1] ? ~last : REQ_ID0;
    end else begin
      sel = REQ_ID1;
    end
  end

endmodule

// File: rtl/adc_sample_scheduler.sv
// rtl/adc_sample_scheduler.sv - shares one MCP3002 SPI front-end between two requesters
//
// Purpose: round-robin arbitration between logger channels 0 and 1, issues one
//          conversion per grant, waits for completion and returns the sample
//          tagged with the requester index.
// Build option: SCHED_TIMEOUT_EN adds a WAIT-state timeout that aborts with
//          data_err; without it WAIT waits indefinitely and data_err is 0.
// Ports:
//   CLKsample  in  1         scheduler clock
//   RESET      in  1         asynchronous active-low reset
//   req        in  2         request levels, dropped on seeing grant
//   grant      out 2         one-hot one-cycle acknowledge
//   conv_start out 1         one-cycle conversion command
//   conv_ch    out 1         ADC channel of the conversion
//   conv_done  in  1         one-cycle completion pulse; sample_in valid
//   sample_in  in  SAMPLE_W  converted sample
//   data_out   out SAMPLE_W  delivered sample
//   data_valid out 1         one-cycle strobe for data_out/data_tag
//   data_tag   out 1         requester index of the delivered sample
//   data_err   out 1         one-cycle abort strobe
//   busy       out 1         high from ISSUE through DONE

module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  parameter int TMR_W    = TMR_W_DEF
) (
  input  logic                CLKsample,
  input  logic                RESET,
  input  logic [1:0]          req,
  output logic [1:0]          grant,
  output logic                conv_start,
  output logic                conv_ch,
  input  logic                conv_done,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic [SAMPLE_W-1:0] data_out,
  output logic                data_valid,
  output logic                data_tag,
  output logic                data_err,
  output logic                busy
);

  if ((TIMEOUT < 1) || ((2 ** TMR_W) <= TIMEOUT)) begin : g_bad_params
    $error("adc_sample_scheduler: TIMEOUT must be >= 1 and below 2**TMR_W");
  end

  sched_state_t state, state_nxt;
  logic sel, sel_nxt;
  logic last_grant, last_nxt;
  logic pick, any;

  logic [1:0]          grant_nxt;
  logic                conv_start_nxt, conv_ch_nxt;
  logic [SAMPLE_W-1:0] data_out_nxt;
  logic                data_valid_nxt, data_tag_nxt, data_err_nxt, busy_nxt;
  logic                timeout_hit;

  rr_arb2 u_arb (
    .req  (req),
    .last (last_grant),
    .sel  (pick),
    .any  (any)
  );

`ifdef SCHED_TIMEOUT_EN
  logic [TMR_W-1:0] timer;

  // Cleared in ISSUE so every WAIT starts counting from zero; saturates so a
  // misconfigured limit can never wrap back into an early abort.
  always_ff @(posedge CLKsample or negedge RESET) begin
    if (!RESET) begin
      timer <= '0;
    end else if (state == ST_ISSUE) begin
      timer <= '0;
    end else if ((state == ST_WAIT) && !conv_done && (timer != '1)) begin
      timer <= timer + TMR_W'(1);
    end
  end

  assign timeout_hit = (timer == TMR_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    last_nxt       = last_grant;
    grant_nxt      = 2'b00;
    conv_start_nxt = 1'b0;
    conv_ch_nxt    = conv_ch;
    data_out_nxt   = data_out;
    data_valid_nxt = 1'b0;
    data_tag_nxt   = data_tag;
    data_err_nxt   = 1'b0;
    busy_nxt       = busy;

    unique case (state)
      ST_IDLE: begin
        if (any) begin
          sel_nxt        = pick;
          conv_start_nxt = 1'b1;
          conv_ch_nxt    = pick;
          grant_nxt      = id_onehot(pick);
          busy_nxt       = 1'b1;
          state_nxt      = ST_ISSUE;
        end
      end
      // conv_done is deliberately not looked at here: a completion arriving
      // before WAIT belongs to no conversion of ours.
      ST_ISSUE: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (conv_done) begin
          data_out_nxt   = sample_in;
          data_tag_nxt   = sel;
          data_valid_nxt = 1'b1;
          last_nxt       = sel;
          state_nxt      = ST_DONE;
        end else if (timeout_hit) begin
          data_err_nxt = 1'b1;
          last_nxt     = sel;
          state_nxt    = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLKsample or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      sel        <= REQ_ID0;
      last_grant <= REQ_ID1;
      grant      <= 2'b00;
      conv_start <= 1'b0;
      conv_ch    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      data_tag   <= 1'b0;
      data_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last_grant <= last_nxt;
      grant      <= grant_nxt;
      conv_start <= conv_start_nxt;
      conv_ch    <= conv_ch_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      data_tag   <= data_tag_nxt;
      data_err   <= data_err_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb/tb_adc_sample_scheduler.sv - self-checking bench for adc_sample_scheduler

`timescale 1ns/1ps

module tb_adc_sample_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic       conv_done = 1'b0;
  logic [7:0] sample_in = 8'h00;

  logic [1:0] grant;
  logic       conv_start, conv_ch, data_valid, data_tag, data_err, busy;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;
  int model_last = 1;

  always #160 clk = ~clk;

  adc_sample_scheduler dut (
    .CLKsample  (clk),
    .RESET      (rst_n),
    .req        (req),
    .grant      (grant),
    .conv_start (conv_start),
    .conv_ch    (conv_ch),
    .conv_done  (conv_done),
    .sample_in  (sample_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_tag   (data_tag),
    .data_err   (data_err),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: a lone requester wins; on contention the one not
  // served last wins.
  function automatic int pick(input logic [1:0] pat);
    if (pat == 2'b11) return 1 - model_last;
    return (pat == 2'b10) ? 1 : 0;
  endfunction

  // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle.
  task automatic txn(input logic [1:0] pat, input int dly, input bit stray_issue,
                     input bit keep_req, input bit stray_idle, input int fixed_smp);
    int exp_sel;
    int n;
    logic [7:0] smp;
    exp_sel = pick(pat);
    req = pat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == 2'b00 && n < 4);
    check("grant_latency", n, 1);
    check("grant", grant, (exp_sel == 1) ? 2'b10 : 2'b01);
    check("conv_start", conv_start, 1);
    check("conv_ch", conv_ch, exp_sel);
    check("busy_issue", busy, 1);
    if (!keep_req) req = 2'b00;
    conv_done = stray_issue;
    sample_in = 8'($urandom);
    @(negedge clk);
    conv_done = 1'b0;
    check("start_one_cycle", {grant, conv_start}, 0);
    repeat (dly) @(negedge clk);
    check("no_early_valid", data_valid, 0);
    check("busy_wait", busy, 1);
    smp = (fixed_smp >= 0) ? 8'(fixed_smp) : 8'($urandom);
    sample_in = smp;
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    sample_in = 8'($urandom);
    check("data_valid", data_valid, 1);
    check("data_out", data_out, smp);
    check("data_tag", data_tag, exp_sel);
    check("data_err_clear", data_err, 0);
    model_last = exp_sel;
    @(negedge clk);
    check("valid_one_cycle", data_valid, 0);
    check("busy_drop", busy, 0);
    if (stray_idle && !keep_req) begin
      conv_done = 1'b1;
      @(negedge clk);
      conv_done = 1'b0;
      check("idle_done_ignored", {data_valid, busy}, 0);
    end
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic tmo(input bit done_same);
    int exp_sel;
    logic [7:0] smp;
    exp_sel = pick(2'b11);
    req = 2'b11;
    @(negedge clk);
    check("tmo_grant", grant, (exp_sel == 1) ? 2'b10 : 2'b01);
    req = 2'b00;
    @(negedge clk);
    repeat (31) @(negedge clk);
    check("tmo_not_early", data_err, 0);
    smp = 8'($urandom);
    if (done_same) begin
      conv_done = 1'b1;
      sample_in = smp;
    end
    @(negedge clk);
    conv_done = 1'b0;
    if (done_same) begin
      check("tmo_done_wins_valid", data_valid, 1);
      check("tmo_done_wins_err", data_err, 0);
      check("tmo_done_wins_data", data_out, smp);
    end else begin
      check("tmo_err", data_err, 1);
      check("tmo_no_valid", data_valid, 0);
    end
    model_last = exp_sel;
    @(negedge clk);
    check("tmo_err_one_cycle", data_err, 0);
    check("tmo_busy_drop", busy, 0);
  endtask
`endif

  initial begin
    #(320 * 20000);
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {grant, conv_start, conv_ch, data_valid, data_tag, data_err, busy, data_out}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention straight after reset: 0,1,0,1.
    for (int i = 0; i < 4; i++) txn(2'b11, 15, 1'b0, (i < 3), 1'b0, -1);

    // Single requester 0, done 16 cycles after conv_start.
    txn(2'b01, 15, 1'b0, 1'b0, 1'b0, 'hA5);

    // Stray completions in ISSUE and IDLE.
    txn(2'b10, 5, 1'b1, 1'b0, 1'b1, -1);

    for (int i = 0; i < 40; i++) begin
      txn(2'($urandom_range(1, 3)), $urandom_range(0, 20), 1'($urandom),
          1'b0, 1'($urandom), -1);
    end

    // Reset mid-WAIT after requester 0 was served last.
    txn(2'b01, 3, 1'b0, 1'b0, 1'b0, -1);
    req = 2'b11;
    @(negedge clk);
    check("pre_reset_grant", grant, 2'b10);
    req = 2'b00;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {grant, conv_start, conv_ch, data_valid, data_tag, data_err, busy, data_out}, 0);
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1;
    @(negedge clk);
    check("post_reset_quiet", {data_valid, busy}, 0);
    txn(2'b11, 7, 1'b0, 1'b0, 1'b0, -1);

`ifdef SCHED_TIMEOUT_EN
    tmo(1'b0);
    txn(2'b11, 4, 1'b0, 1'b0, 1'b0, -1);
    tmo(1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_scheduler.md
Name: adc_sample_scheduler

Overview:
Shares the single MCP3002 SPI front-end between two requesters (logger channel 0 and channel 1).
- Runs in the CLKsample domain, between the SPI leader and downstream logging logic.
- Arbitrates round-robin and issues one conversion command with a channel select.
- Waits for the conversion-complete pulse, then returns the 8-bit sample tagged with the requester ID.

Parameters:
SAMPLE_W, 8, sample word width (matches the SPI leader's Sample_word)
TIMEOUT, 32, CLKsample cycles allowed in WAIT before abort (only used when SCHED_TIMEOUT_EN is defined)
TMR_W, 6, timeout counter width; must satisfy 2^TMR_W > TIMEOUT

Ports:
CLKsample  in   1         scheduler clock (3.125 MHz sample clock)
RESET      in   1         asynchronous, active-low reset
req        in   2         per-requester request level; held until the matching grant bit is seen
grant      out  2         one-hot, one-cycle acknowledge of the accepted request
conv_start out  1         one-cycle pulse commanding the SPI leader to run a conversion
conv_ch    out  1         ADC channel for the conversion (equals the selected requester index)
conv_done  in   1         one-cycle pulse from the SPI leader; sample_in is valid in that cycle
sample_in  in   SAMPLE_W  converted sample from the SPI leader
data_out   out  SAMPLE_W  delivered sample
data_valid out  1         one-cycle strobe qualifying data_out and data_tag
data_tag   out  1         requester index of the delivered sample
data_err   out  1         one-cycle abort strobe (tied 0 when the feature is out)
busy       out  1         high from ISSUE through DONE inclusive

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE; all outputs 0; last_grant=1, so requester 0 wins the first contention; timer=0.
- All registered outputs update on posedge CLKsample.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: latch sel, then go to ISSUE with conv_start=1, conv_ch=sel, grant=onehot(sel), busy=1.
  - Only one requester: sel is that requester.
  - Both requesting: sel = ~last_grant (round-robin).
- ISSUE: lasts exactly one cycle. conv_start=0, grant=0, timer=0, go to WAIT.
  - conv_done in ISSUE is ignored, so no stale completion is accepted.
- WAIT, conv_done=1: data_out=sample_in, data_tag=sel, data_valid=1, last_grant=sel, go to DONE.
- WAIT, conv_done=0: timer increments and saturates at 2^TMR_W-1.
- DONE: data_valid=0, data_err=0, busy=0, go to IDLE. This gives one guaranteed idle cycle between conversions.
- Latency: req to grant/conv_start is 1 edge; conv_done edge to data_valid is 1 edge.
- A request still asserted in IDLE counts as a new request; requesters must drop req on seeing grant.
- req changes outside IDLE are ignored.
- conv_done outside WAIT is discarded.
- Reset mid-operation: immediate return to IDLE; any in-flight sample is dropped and no data_valid is issued.

Optional Feature:
SCHED_TIMEOUT_EN
- Defined: in WAIT, when timer==TIMEOUT-1 and conv_done=0, assert data_err=1 for one cycle with data_valid=0, set last_grant=sel, go to DONE.
  - If conv_done=1 in that same cycle, conv_done wins: normal delivery, no data_err.
- Undefined: no timer logic is built; WAIT waits indefinitely; data_err is tied to 0.

Decomposition:
- Package adc_sched_pkg: state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3), SAMPLE_W default, TIMEOUT default, requester-ID constants.
- One natural sub-module, rr_arb2: 2-way round-robin picker. Inputs req[1:0] and last; outputs sel and any. Purely combinational; the pointer state stays in the parent.

Test Plan:
1. req=01; conv_done 16 cycles after conv_start with sample_in=0xA5 -> grant=01 and conv_start one cycle, conv_ch=0; one cycle after done: data_out=0xA5, data_valid=1, data_tag=0.
2. req=11 held after reset -> first grant=01 (ch0), then grant=10 (ch1), then alternates; with done at 16 cycles, data_tag sequence is 0,1,0,1.
3. conv_done pulsed in ISSUE and in IDLE -> no data_valid; FSM remains in WAIT until a real done.
4. SCHED_TIMEOUT_EN, no conv_done -> data_err one cycle exactly 32 cycles after entering WAIT; busy drops the next cycle; next contention grants the other requester.
5. SCHED_TIMEOUT_EN, conv_done in the same cycle as the timeout -> data_valid=1, data_err=0.
6. RESET low mid-WAIT for 2 cycles -> all outputs 0 immediately; after release with req=11, first grant=01.
